lcd_dither_out: RTL and testbench

//  Output stage between the pixel renderer/timing generator and the LCD pins.

---
 rtl/lcd_pkg.sv | 19 +
 rtl/lcd_bayer_lut.sv | 14 +
 rtl/lcd_dither_out.sv | 120 ++++++++++++
 tb/tb_lcd_dither_out.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared LCD output constants: pin widths, Bayer threshold table, pipe latency.
package lcd_pkg;

  localparam int unsigned LCD_R_W     = 8;
  localparam int unsigned LCD_G_W     = 6;
  localparam int unsigned LCD_B_W     = 8;

  // Pixel/sync latency through lcd_dither_out; the timing generator aligns to this.
  localparam int unsigned OUT_LATENCY = 2;

  // 4x4 ordered-dither matrix, row-major, indexed by {y[1:0], x[1:0]}.
  localparam logic [3:0] BAYER4 [16] = '{
    4'd0,  4'd8,  4'd2,  4'd10,
    4'd12, 4'd4,  4'd14, 4'd6,
    4'd3,  4'd11, 4'd1,  4'd9,
    4'd15, 4'd7,  4'd13, 4'd5
  };

endpackage

// File: rtl/lcd_bayer_lut.sv
// Combinational Bayer lookup: {y,x} index to 4-bit threshold.
module lcd_bayer_lut
  import lcd_pkg::*;
(
  input  logic [3:0] idx,
  output logic [3:0] thr
);

  // Table lookup.
  always_comb begin
    thr = BAYER4[idx];
  end

endmodule

// File: rtl/lcd_dither_out.sv
// LCD output stage: green 8->(8-G_DROP) with spatial+temporal dither,
// red/blue/syncs carried through a matching 2-stage pipe.
module lcd_dither_out
  import lcd_pkg::*;
#(
  parameter int unsigned G_DROP = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dither_en,
  input  logic                 de_in,
  input  logic                 hsync_in,
  input  logic                 vsync_in,
  input  logic [LCD_R_W-1:0]   r_in,
  input  logic [7:0]           g_in,
  input  logic [LCD_B_W-1:0]   b_in,
  output logic                 de,
  output logic                 hsync,
  output logic                 vsync,
  output logic [LCD_R_W-1:0]   r,
  output logic [8-G_DROP-1:0]  g,
  output logic [LCD_B_W-1:0]   b
);

  localparam int unsigned GW = 8 - G_DROP;

  logic [1:0] col, line, frame;
  logic [1:0] xi, yi;
  logic [3:0] bay, thr_c;
  logic       de_fall, vs_edge;

  // Stage-1 registers; de_s1/vs_s1 double as the edge-detect history.
  logic               de_s1, hs_s1, vs_s1;
  logic [LCD_R_W-1:0] r_s1;
  logic [7:0]         g_s1;
  logic [LCD_B_W-1:0] b_s1;
  logic [3:0]         thr_s1;

  logic [8:0]    sum;
  logic [GW-1:0] g_sat;

  // Dither phase and threshold selection from input-side signals.
  always_comb begin
    xi      = col + {1'b0, frame[0]};
    yi      = line + {1'b0, frame[1]};
    de_fall = de_s1 & ~de_in;
    vs_edge = vs_s1 & ~vsync_in;
    thr_c   = '0;
    if (dither_en && de_in) thr_c = bay >> (4 - G_DROP);
  end

  lcd_bayer_lut u_lut (
    .idx ({yi, xi}),
    .thr (bay)
  );

  // Column / line / frame phase counters; a vsync edge overrides a line step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col   <= '0;
      line  <= '0;
      frame <= '0;
    end else begin
      col <= de_in ? col + 2'd1 : '0;
      if (vs_edge) begin
        line  <= '0;
        frame <= frame + 2'd1;
      end else if (de_fall) begin
        line  <= line + 2'd1;
      end
    end
  end

  // Stage 1: register inputs and the selected threshold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_s1  <= 1'b0;
      hs_s1  <= 1'b1;
      vs_s1  <= 1'b1;
      r_s1   <= '0;
      g_s1   <= '0;
      b_s1   <= '0;
      thr_s1 <= '0;
    end else begin
      de_s1  <= de_in;
      hs_s1  <= hsync_in;
      vs_s1  <= vsync_in;
      r_s1   <= r_in;
      g_s1   <= g_in;
      b_s1   <= b_in;
      thr_s1 <= thr_c;
    end
  end

  // Saturating green add-and-truncate.
  always_comb begin
    sum   = {1'b0, g_s1} + {5'b0, thr_s1};
    g_sat = sum[8] ? '1 : GW'(sum >> G_DROP);
  end

  // Stage 2: output registers driving the pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de    <= 1'b0;
      hsync <= 1'b1;
      vsync <= 1'b1;
      r     <= '0;
      g     <= '0;
      b     <= '0;
    end else begin
      de    <= de_s1;
      hsync <= hs_s1;
      vsync <= vs_s1;
      r     <= r_s1;
      g     <= g_sat;
      b     <= b_s1;
    end
  end

endmodule

// File: tb/tb_lcd_dither_out.sv
// Scoreboard bench for lcd_dither_out: stimulus pushes expected pixels,
// a monitor pops them as DE pixels emerge and checks sync alignment.
module tb_lcd_dither_out;
  import lcd_pkg::*;

  typedef struct {
    logic [7:0] r;
    logic [5:0] g;
    logic [7:0] b;
  } px_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       dither_en, de_in, hsync_in, vsync_in;
  logic [7:0] r_in, g_in, b_in;
  logic       de, hsync, vsync;
  logic [7:0] r, b;
  logic [5:0] g;

  px_t q[$];
  int  checks   = 0;
  int  failures = 0;
  bit  done     = 1'b0;

  // Bench-side record of driven syncs, delayed OUT_LATENCY clocks.
  logic h1_de = 1'b0, h1_hs = 1'b1, h1_vs = 1'b1;
  logic h2_de = 1'b0, h2_hs = 1'b1, h2_vs = 1'b1;

  lcd_dither_out #(.G_DROP(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .dither_en (dither_en),
    .de_in     (de_in),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .r_in      (r_in),
    .g_in      (g_in),
    .b_in      (b_in),
    .de        (de),
    .hsync     (hsync),
    .vsync     (vsync),
    .r         (r),
    .g         (g),
    .b         (b)
  );

  always #5 clk = ~clk;

  // Two-deep history of the sync inputs this bench drove.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      h1_de <= 1'b0; h1_hs <= 1'b1; h1_vs <= 1'b1;
      h2_de <= 1'b0; h2_hs <= 1'b1; h2_vs <= 1'b1;
    end else begin
      h1_de <= de_in; h1_hs <= hsync_in; h1_vs <= vsync_in;
      h2_de <= h1_de; h2_hs <= h1_hs;    h2_vs <= h1_vs;
    end
  end

  task automatic cyc(input logic d, input logic hs, input logic vs,
                     input logic [7:0] rv, input logic [7:0] gv,
                     input logic [7:0] bv, input logic [5:0] eg);
    px_t e;
    de_in = d; hsync_in = hs; vsync_in = vs;
    r_in = rv; g_in = gv; b_in = bv;
    if (d) begin
      e.r = rv; e.g = eg; e.b = bv;
      q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 6'h00);
  endtask

  task automatic burst(input logic [7:0] gv, input logic [5:0] e0, input logic [5:0] e1,
                       input logic [5:0] e2, input logic [5:0] e3);
    cyc(1'b1, 1'b1, 1'b1, 8'hA0, gv, 8'h50, e0);
    cyc(1'b1, 1'b1, 1'b1, 8'hA1, gv, 8'h51, e1);
    cyc(1'b1, 1'b1, 1'b1, 8'hA2, gv, 8'h52, e2);
    cyc(1'b1, 1'b1, 1'b1, 8'hA3, gv, 8'h53, e3);
  endtask

  task automatic reset_pulse();
    #2 rst = 1'b1;
    de_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Stimulus.
  initial begin
    rst = 1'b0; dither_en = 1'b0;
    de_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    r_in = '0; g_in = '0; b_in = '0;
    #2 rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Bypass: plain truncation.
    cyc(1'b1, 1'b1, 1'b1, 8'h12, 8'hAB, 8'h34, 6'h2A);
    cyc(1'b1, 1'b1, 1'b1, 8'h56, 8'h03, 8'h78, 6'h00);
    idle(3);

    // Advance frame, then reset mid-burst; phase must restart at frame 0.
    dither_en = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 6'h00);
    cyc(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 6'h00);
    cyc(1'b1, 1'b1, 1'b1, 8'h77, 8'h40, 8'h66, 6'h10);
    cyc(1'b1, 1'b1, 1'b1, 8'h78, 8'h40, 8'h67, 6'h10);
    reset_pulse();
    burst(8'h02, 6'd0, 6'd1, 6'd0, 6'd1);
    idle(2);

    // Saturation over all lines and two frames.
    for (int unsigned f = 0; f < 2; f++) begin
      for (int unsigned l = 0; l < 4; l++) begin
        burst(8'hFF, 6'h3F, 6'h3F, 6'h3F, 6'h3F);
        idle(2);
      end
      cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 6'h00);
      idle(2);
    end

    // Spatial pattern, lines 0 and 1 of frame 0.
    reset_pulse();
    burst(8'h02, 6'd0, 6'd1, 6'd0, 6'd1);
    idle(2);
    burst(8'h02, 6'd1, 6'd0, 6'd1, 6'd0);
    idle(2);

    // Temporal: one vsync assertion shifts x phase.
    reset_pulse();
    idle(1);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 6'h00);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 6'h00);
    idle(2);
    burst(8'h02, 6'd1, 6'd0, 6'd1, 6'd0);
    idle(2);

    // DE fall and vsync assertion on the same clock: line must be 0.
    reset_pulse();
    burst(8'h02, 6'd0, 6'd1, 6'd0, 6'd1);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 6'h00);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 6'h00);
    idle(2);
    burst(8'h02, 6'd1, 6'd0, 6'd1, 6'd0);
    idle(2);

    // Random control toggles for alignment, bypass data.
    dither_en = 1'b0;
    for (int unsigned i = 0; i < 200; i++) begin
      logic       d, hs, vs;
      logic [7:0] rv, gv, bv;
      d  = 1'($urandom_range(0, 1));
      hs = 1'($urandom_range(0, 1));
      vs = 1'($urandom_range(0, 1));
      rv = 8'($urandom); gv = 8'($urandom); bv = 8'($urandom);
      cyc(d, hs, vs, rv, gv, bv, 6'(gv >> 2));
    end
    idle(4);
    done = 1'b1;
  end

  // Monitor: reset-value checks, sync alignment, scoreboard pops.
  initial begin
    bit          in_rst = 1'b0;
    int unsigned ncyc   = 0;
    px_t         e;
    while (!done) begin
      @(negedge clk or posedge rst);
      if (rst && !in_rst) begin
        in_rst = 1'b1;
        #1;
        q.delete();
        checks++;
        if (de !== 1'b0 || hsync !== 1'b1 || vsync !== 1'b1) begin
          failures++;
          $display("FAIL reset_sync got de=%b hs=%b vs=%b want de=0 hs=1 vs=1", de, hsync, vsync);
        end
        checks++;
        if (r !== 8'h00 || g !== 6'h00 || b !== 8'h00) begin
          failures++;
          $display("FAIL reset_rgb got r=%h g=%h b=%h want 00 00 00", r, g, b);
        end
      end else if (!rst) begin
        in_rst = 1'b0;
        ncyc++;
        if (ncyc > 20000) begin
          failures++;
          $display("FAIL watchdog cycles=%0d limit=20000", ncyc);
          break;
        end
        checks++;
        if (de !== h2_de || hsync !== h2_hs || vsync !== h2_vs) begin
          failures++;
          $display("FAIL sync_align t=%0t got de=%b hs=%b vs=%b want de=%b hs=%b vs=%b",
                   $time, de, hsync, vsync, h2_de, h2_hs, h2_vs);
        end
        if (de === 1'b1) begin
          checks++;
          if (q.size() == 0) begin
            failures++;
            $display("FAIL pixel_unexpected t=%0t got r=%h g=%h b=%h want no pixel", $time, r, g, b);
          end else begin
            e = q.pop_front();
            if (r !== e.r || g !== e.g || b !== e.b) begin
              failures++;
              $display("FAIL pixel t=%0t got r=%h g=%h b=%h want r=%h g=%h b=%h",
                       $time, r, g, b, e.r, e.g, e.b);
            end
          end
        end
      end
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
